// File: rtl/leitor_fila_if.sv
// rtl/leitor_fila_if.sv - queue-side and serial-side signals of the queue drain reader
interface leitor_fila_if;
    logic       enable;
    logic [7:0] len_in;
    logic [7:0] data_in;
    logic       dequeue_out;
    logic       serial_out;
    logic       valid_out;
    logic       busy_out;
    logic [7:0] byte_count_out;

    modport master (
        output enable, len_in, data_in,
        input  dequeue_out, serial_out, valid_out, busy_out, byte_count_out
    );

    modport slave (
        input  enable, len_in, data_in,
        output dequeue_out, serial_out, valid_out, busy_out, byte_count_out
    );
endinterface

// File: rtl/leitor_fila.sv
// rtl/leitor_fila.sv - drains one byte at a time from the byte queue and shifts it out MSB-first
module leitor_fila #(
    parameter int unsigned THRESHOLD = 1
) (
    input  logic          clk_10KHz,
    input  logic          reset,
    leitor_fila_if.slave  fila
);
    localparam int unsigned TH_EFF = (THRESHOLD == 0) ? 1 : THRESHOLD;
    localparam logic [7:0]  W_TH   = 8'(TH_EFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEQ,
        S_LOAD,
        S_SEND,
        S_GAP
    } state_t;

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    logic       r_dequeue;
    logic       r_serial;
    logic       r_valid;
    logic       r_busy;
    logic [7:0] r_byte_count;
    logic       w_start;

    assign w_start = fila.enable && (fila.len_in != 8'd0) && (fila.len_in >= W_TH);

    assign fila.dequeue_out    = r_dequeue;
    assign fila.serial_out     = r_serial;
    assign fila.valid_out      = r_valid;
    assign fila.busy_out       = r_busy;
    assign fila.byte_count_out = r_byte_count;

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_shift      <= 8'd0;
            r_cnt        <= 3'd0;
            r_dequeue    <= 1'b0;
            r_serial     <= 1'b0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_byte_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_dequeue <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_DEQ;
                    end
                end
                S_DEQ: begin
                    r_dequeue <= 1'b0;
                    r_state   <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift  <= fila.data_in;
                    r_serial <= fila.data_in[7];
                    r_valid  <= 1'b1;
                    r_cnt    <= 3'd0;
                    r_state  <= S_SEND;
                end
                S_SEND: begin
                    // counter at 7 means bit0 has already been on the line for a full cycle
                    if (r_cnt == 3'd7) begin
                        r_valid      <= 1'b0;
                        r_serial     <= 1'b0;
                        r_byte_count <= r_byte_count + 8'd1;
                        r_state      <= S_GAP;
                    end else begin
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_serial <= r_shift[6];
                        r_cnt    <= r_cnt + 3'd1;
                    end
                end
                S_GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_dequeue <= 1'b0;
                    r_valid   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_leitor_fila.sv
// tb/tb_leitor_fila.sv - directed self-checking bench for leitor_fila
module tb_leitor_fila;
    logic clk_10KHz = 1'b0;
    logic reset     = 1'b1;

    leitor_fila_if b1 ();
    leitor_fila_if b2 ();

    leitor_fila #(.THRESHOLD(1)) dut (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .fila      (b1.slave)
    );

    leitor_fila #(.THRESHOLD(4)) dut_th (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .fila      (b2.slave)
    );

    always #5 clk_10KHz = ~clk_10KHz;

    // queue model for b1: data_out is registered and updated by the dequeue pulse
    logic [7:0] qmem [0:255];
    int         qtail    = 0;
    int         qhead    = 0;
    logic [7:0] qdata    = 8'd0;
    int         cyc      = 0;
    logic       en1      = 1'b0;
    logic       en2      = 1'b0;
    logic [7:0] len2     = 8'd0;
    logic [7:0] data2    = 8'h3C;

    assign b1.enable  = en1;
    assign b1.len_in  = 8'(qtail - qhead);
    assign b1.data_in = qdata;
    assign b2.enable  = en2;
    assign b2.len_in  = len2;
    assign b2.data_in = data2;

    always @(posedge clk_10KHz) begin
        cyc <= cyc + 1;
        if (b1.dequeue_out) begin
            qdata <= qmem[qhead[7:0]];
            qhead <= qhead + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic f_deq(input int w);
        return (w == 0) ? b1.dequeue_out : b2.dequeue_out;
    endfunction
    function automatic logic f_ser(input int w);
        return (w == 0) ? b1.serial_out : b2.serial_out;
    endfunction
    function automatic logic f_val(input int w);
        return (w == 0) ? b1.valid_out : b2.valid_out;
    endfunction
    function automatic logic f_busy(input int w);
        return (w == 0) ? b1.busy_out : b2.busy_out;
    endfunction
    function automatic logic [7:0] f_cnt(input int w);
        return (w == 0) ? b1.byte_count_out : b2.byte_count_out;
    endfunction

    // waits for a dequeue pulse, then checks the whole serial frame; returns at E11's negedge
    task automatic xfer(input int w, input logic [7:0] exp_byte, input logic [7:0] exp_cnt,
                        input int drop_at, output int pulse_cyc);
        bit found = 0;
        pulse_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (f_deq(w)) begin
                found = 1;
                break;
            end
            @(negedge clk_10KHz);
        end
        if (!found) begin
            chk("deq_timeout", 8'd0, 8'd1);
            return;
        end
        pulse_cyc = cyc;
        chk("busy_e0", 8'(f_busy(w)), 8'd1);
        @(negedge clk_10KHz);
        chk("deq_one_cycle", 8'(f_deq(w)), 8'd0);
        @(negedge clk_10KHz);
        for (int b = 7; b >= 0; b--) begin
            chk("valid_bit", 8'(f_val(w)), 8'd1);
            chk("serial_bit", 8'(f_ser(w)), 8'(exp_byte[b]));
            chk("busy_bit", 8'(f_busy(w)), 8'd1);
            if (b == drop_at) begin
                if (w == 0) en1 = 1'b0;
                else        en2 = 1'b0;
            end
            @(negedge clk_10KHz);
        end
        chk("valid_end", 8'(f_val(w)), 8'd0);
        chk("serial_end", 8'(f_ser(w)), 8'd0);
        chk("count", f_cnt(w), exp_cnt);
        chk("busy_gap", 8'(f_busy(w)), 8'd1);
        @(negedge clk_10KHz);
        chk("busy_idle", 8'(f_busy(w)), 8'd0);
    endtask

    int pc0, pc1, pc2, pcx;
    bit found_rst;

    initial begin
        // reset state
        repeat (2) @(negedge clk_10KHz);
        chk("rst_deq", 8'(b1.dequeue_out), 8'd0);
        chk("rst_ser", 8'(b1.serial_out), 8'd0);
        chk("rst_val", 8'(b1.valid_out), 8'd0);
        chk("rst_busy", 8'(b1.busy_out), 8'd0);
        chk("rst_cnt", b1.byte_count_out, 8'd0);
        reset = 1'b0;
        en1   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_10KHz);
            chk("empty_no_deq", 8'(b1.dequeue_out), 8'd0);
        end

        // single byte
        qmem[0] = 8'hA5;
        qtail   = 1;
        @(negedge clk_10KHz);
        xfer(0, 8'hA5, 8'd1, -1, pcx);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_10KHz);
            chk("single_no_2nd", 8'(b1.dequeue_out), 8'd0);
        end

        // back-to-back
        qmem[1] = 8'h01;
        qmem[2] = 8'h80;
        qmem[3] = 8'hFF;
        qtail   = 4;
        xfer(0, 8'h01, 8'd2, -1, pc0);
        xfer(0, 8'h80, 8'd3, -1, pc1);
        xfer(0, 8'hFF, 8'd4, -1, pc2);
        chk("b2b_gap1", 8'(pc1 - pc0), 8'd12);
        chk("b2b_gap2", 8'(pc2 - pc1), 8'd12);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_10KHz);
            chk("b2b_no_4th", 8'(b1.dequeue_out), 8'd0);
        end
        chk("b2b_len", b1.len_in, 8'd0);
        chk("b2b_cnt", b1.byte_count_out, 8'd4);
        en1 = 1'b0;

        // threshold 4
        en2 = 1'b1;
        for (int l = 1; l <= 3; l++) begin
            len2 = 8'(l);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_10KHz);
                chk("th_below", 8'(b2.dequeue_out), 8'd0);
            end
        end
        len2 = 8'd4;
        @(negedge clk_10KHz);
        chk("th_fire", 8'(b2.dequeue_out), 8'd1);

        // enable drop during bit 3
        xfer(1, 8'h3C, 8'd1, 3, pcx);
        len2 = 8'd5;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_10KHz);
            chk("drop_no_deq", 8'(b2.dequeue_out), 8'd0);
        end
        chk("drop_idle", 8'(b2.busy_out), 8'd0);

        // reset mid-byte
        en2       = 1'b1;
        found_rst = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_10KHz);
            if (b2.dequeue_out) begin
                found_rst = 1;
                break;
            end
        end
        chk("rstmid_found", 8'(found_rst), 8'd1);
        repeat (4) @(negedge clk_10KHz);
        chk("rstmid_valid_pre", 8'(b2.valid_out), 8'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_valid", 8'(b2.valid_out), 8'd0);
        chk("rstmid_ser", 8'(b2.serial_out), 8'd0);
        chk("rstmid_busy", 8'(b2.busy_out), 8'd0);
        chk("rstmid_cnt", b2.byte_count_out, 8'd0);
        en2 = 1'b0;
        @(negedge clk_10KHz);
        reset = 1'b0;
        repeat (15) @(negedge clk_10KHz);
        chk("rstmid_cnt_hold", b2.byte_count_out, 8'd0);
        chk("rstmid_no_deq", 8'(b2.dequeue_out), 8'd0);

        // 256 bytes wrap the counter
        en2 = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            xfer(1, 8'h3C, 8'(k), -1, pcx);
        end
        chk("wrap_cnt", b2.byte_count_out, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/leitor_fila.md
# leitor_fila

Drain-side consumer for the 8-entry byte queue. Watches the queue length, issues single-cycle dequeue pulses, captures the byte the queue presents and shifts it out MSB-first on a serial line with a valid strobe. It sits directly downstream of the queue, on the same `clk_10KHz` domain, and is the reader counterpart to whatever block performs enqueues.

## Interface
- `THRESHOLD`, default 1: minimum queue length (1..8) before a byte is drained; a value of 0 behaves as 1.
- `clk_10KHz` in 1: single clock. Everything is sampled on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: drain permission. Sampled only in IDLE.
- `len_in` in 8: queue occupancy (the queue's `len_out`).
- `data_in` in 8: byte presented by the queue (the queue's `data_out`).
- `dequeue_out` out 1: one-cycle dequeue pulse to the queue.
- `serial_out` out 1: serial data, MSB first, one bit per clock.
- `valid_out` out 1: high exactly while a data bit is on `serial_out`.
- `busy_out` out 1: high in every state except IDLE.
- `byte_count_out` out 8: count of bytes fully transmitted; wraps from 255 to 0.

## Operation
- FSM states: IDLE, DEQ, LOAD, SEND, GAP. All outputs are registered.
- **IDLE**
  - If `enable`=1, `len_in`!=0 and `len_in`>=max(THRESHOLD,1): set `dequeue_out`<=1 and go to DEQ.
  - Otherwise stay in IDLE.
- **DEQ**
  - `dequeue_out`<=0 and go to LOAD.
  - During this state the queue samples the pulse, updates `data_in` and decrements `len_in`.
- **LOAD**
  - Capture `data_in` into the 8-bit shift register.
  - `serial_out`<=bit7, `valid_out`<=1, bit counter<=0, go to SEND.
- **SEND**
  - Each edge: shift left, `serial_out`<=next bit, counter+1.
  - After bit0 has been held for one cycle (counter reaches 7): `valid_out`<=0, `serial_out`<=0, `byte_count_out`<=`byte_count_out`+1 (mod 256), go to GAP.
- **GAP**
  - One idle cycle with `valid_out`=0, then go to IDLE.
- `enable` falling in any non-IDLE state does not abort the byte. The byte completes and the FSM then stays in IDLE.
- `len_in` and `data_in` are ignored outside IDLE and LOAD respectively.
- Changes to `len_in` from concurrent enqueues are harmless: the block never issues a second dequeue before returning to IDLE.
- Reset values: state IDLE, `dequeue_out`=0, `serial_out`=0, `valid_out`=0, `busy_out`=0, `byte_count_out`=0, shift register 0, counter 0.
- Reset mid-byte: the operation aborts immediately and asynchronously. The already-dequeued byte is lost and is not counted.

## Timing
- Let E0 be the edge at which IDLE decides to drain.
- `dequeue_out`=1 during cycle E0..E1 only.
- Queue updates `data_out` at E1; byte is captured at E2.
- `serial_out` carries bit7 over E2..E3, bit6 over E3..E4, and so on; bit0 over E9..E10. `valid_out`=1 over E2..E10 (8 cycles).
- `byte_count_out` increments at E10. GAP runs E10..E11; IDLE is re-entered at E11.
- Earliest next drain decision is at E12 (next `dequeue_out` high from E12). Sustained throughput is one byte per 12 cycles.
- `busy_out`=1 from E0 through E11.

## Test plan
- **Reset state**
  - Stimulus: assert `reset` asynchronously between edges.
  - Required: all outputs go to 0 immediately; no `dequeue_out` while `len_in`=0 and `enable`=1.
- **Single byte**
  - Stimulus: `len_in`=1, `data_in`=8'hA5 after the dequeue, `enable`=1.
  - Required: one `dequeue_out` pulse; serial bits 1,0,1,0,0,1,0,1 with `valid_out` high for exactly 8 cycles; `byte_count_out` goes 0->1.
- **Back-to-back**
  - Stimulus: queue preloaded with 8'h01, 8'h80, 8'hFF (`len_in` 3->0).
  - Required: three dequeue pulses exactly 12 cycles apart; serial streams 00000001, 10000000, 11111111; final `byte_count_out`=3; no fourth pulse.
- **Threshold**
  - Stimulus: THRESHOLD=4; `len_in` ramps 1,2,3.
  - Required: no dequeue.
  - Stimulus: `len_in` reaches 4.
  - Required: dequeue_out fires on the next edge.
- **Enable drop mid-byte**
  - Stimulus: `enable`->0 during SEND bit 3.
  - Required: byte completes, count increments, then no further dequeue while `len_in`=5.
- **Reset mid-byte / wrap**
  - Stimulus: reset during SEND.
  - Required: `valid_out`=0 at once and `byte_count_out` does not increment.
  - Stimulus: 256 transmitted bytes.
  - Required: `byte_count_out` wraps to 0.
